// File: rtl/multiplier_check_pkg.sv
// Shared types and helpers for the multiplier result checker.
package multiplier_check_pkg;

   // Checker FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2
   } stateT;

   // One verdict per run.
   typedef struct packed {
      logic mismatch;
      logic timingLeak;
      logic timeout;
   } verdictT;

   // Counter width able to hold every value from 0 up to and including timeout.
   function automatic int cntWidth(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/multiplier_result_capture.sv
// One lane of the checker: grabs the product and the cycle count on the
// first done seen while enabled, and ignores every later done.
module multiplier_result_capture #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [CNT_W-1:0]     cnt,
   input  logic [2*WIDTH-1:0]   product,
   input  logic                 productDone,
   output logic [2*WIDTH-1:0]   captured,
   output logic [CNT_W-1:0]     latency,
   output logic                 flag
);

   logic [2*WIDTH-1:0] capturedReg;
   logic [CNT_W-1:0]   latencyReg;
   logic               flagReg;

   // First-done capture; clear wipes the lane at the start of a new run.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         capturedReg <= '0;
         latencyReg  <= '0;
         flagReg     <= 1'b0;
      end else if (enable && productDone && !flagReg) begin
         capturedReg <= product;
         latencyReg  <= cnt;
         flagReg     <= 1'b1;
      end
   end

   assign captured = capturedReg;
   assign latency  = latencyReg;
   assign flag     = flagReg;

endmodule

// File: rtl/multiplier_result_checker.sv
// Watches two multipliers started together, captures each product and its
// latency, and issues one registered verdict per run plus a sticky leak flag.
module multiplier_result_checker
   import multiplier_check_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = cntWidth(TIMEOUT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   productA,
   input  logic                 productDoneA,
   input  logic [2*WIDTH-1:0]   productB,
   input  logic                 productDoneB,
   output logic                 busy,
   output logic                 checkValid,
   output logic                 mismatch,
   output logic                 timingLeak,
   output logic                 timeout,
   output logic [CNT_W-1:0]     latencyA,
   output logic [CNT_W-1:0]     latencyB,
   output logic [2*WIDTH-1:0]   capturedA,
   output logic [2*WIDTH-1:0]   capturedB,
   output logic                 leakSticky
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   stateT              stateReg, stateNext;
   logic               abortReg, abortNext;
   logic [CNT_W-1:0]   cntReg;
   verdictT            verdictReg, verdictNext;
   logic               checkValidReg;
   logic               leakStickyReg;

   logic               laneClear;
   logic               laneEnable;
   logic [2*WIDTH-1:0] laneProduct  [2];
   logic [2*WIDTH-1:0] laneCaptured [2];
   logic [CNT_W-1:0]   laneLatency  [2];
   logic [1:0]         laneDone;
   logic [1:0]         laneFlag;
   logic [1:0]         laneSettled;

   assign laneClear  = (stateReg == IDLE) && start;
   assign laneEnable = (stateReg == RUN);

   assign laneProduct[0] = productA;
   assign laneProduct[1] = productB;
   assign laneDone       = {productDoneB, productDoneA};

   // Lane 0 is A, lane 1 is B. A lane counts as settled on the edge it captures.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gLane
         multiplier_result_capture #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
         ) uCapture (
            .clk         (clk),
            .rst         (rst),
            .clear       (laneClear),
            .enable      (laneEnable),
            .cnt         (cntReg),
            .product     (laneProduct[gi]),
            .productDone (laneDone[gi]),
            .captured    (laneCaptured[gi]),
            .latency     (laneLatency[gi]),
            .flag        (laneFlag[gi])
         );
         assign laneSettled[gi] = laneFlag[gi] | (laneEnable & laneDone[gi]);
      end
   endgenerate

   // State and abort-marker register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
         abortReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         abortReg <= abortNext;
      end
   end

   // Next state: a completed pair wins over a timeout on the same edge.
   always_comb begin
      stateNext = stateReg;
      abortNext = abortReg;
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext = RUN;
               abortNext = 1'b0;
            end
         end
         RUN: begin
            if (&laneSettled) begin
               stateNext = CHECK;
            end else if (cntReg == CNT_MAX) begin
               stateNext = CHECK;
               abortNext = 1'b1;
            end
         end
         CHECK:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Latency counter: 1 on the first RUN cycle, saturating at TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cntReg <= '0;
      end else if (laneClear) begin
         cntReg <= CNT_W'(1);
      end else if (laneEnable && (cntReg != CNT_MAX)) begin
         cntReg <= cntReg + 1'b1;
      end
   end

   // Verdict for the run being checked; an aborted run only reports a leak
   // when exactly one lane ever finished.
   always_comb begin
      verdictNext = '0;
      if (abortReg) begin
         verdictNext.timeout    = 1'b1;
         verdictNext.timingLeak = laneFlag[0] ^ laneFlag[1];
      end else begin
         verdictNext.mismatch   = (laneCaptured[0] != laneCaptured[1]);
         verdictNext.timingLeak = (laneLatency[0] != laneLatency[1]);
      end
   end

   // Verdict, valid pulse and sticky leak flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         verdictReg    <= '0;
         checkValidReg <= 1'b0;
         leakStickyReg <= 1'b0;
      end else begin
         checkValidReg <= (stateReg == CHECK);
         if (laneClear) begin
            verdictReg <= '0;
         end else if (stateReg == CHECK) begin
            verdictReg    <= verdictNext;
            leakStickyReg <= leakStickyReg | verdictNext.timingLeak;
         end
      end
   end

   assign busy       = (stateReg != IDLE);
   assign checkValid = checkValidReg;
   assign mismatch   = verdictReg.mismatch;
   assign timingLeak = verdictReg.timingLeak;
   assign timeout    = verdictReg.timeout;
   assign latencyA   = laneLatency[0];
   assign latencyB   = laneLatency[1];
   assign capturedA  = laneCaptured[0];
   assign capturedB  = laneCaptured[1];
   assign leakSticky = leakStickyReg;

endmodule

// File: doc/multiplier_result_checker.md
Name: multiplier_result_checker

Overview:
- Downstream consumer of two sequential multiplier instances that share one `start` and run as a comparison pair.
- Counts cycles from `start` to each `productDone` and captures each product.
- Then flags a product mismatch (commutativity/equivalence violation) and a latency difference (timing leak between operand sets).
- Produces one registered verdict per run, plus a sticky leak flag for the formal/sim harness.

Parameters:
- WIDTH, 4, operand width of the multipliers; products are 2*WIDTH bits.
- TIMEOUT, 64, maximum cycles to wait for both done pulses before aborting the run.
- CNT_W, $clog2(TIMEOUT+1), latency counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  same start pulse driven to both multipliers; accepted only in IDLE.
- productA  input  2*WIDTH  product of multiplier A.
- productDoneA  input  1  done from multiplier A; level or pulse.
- productB  input  2*WIDTH  product of multiplier B.
- productDoneB  input  1  done from multiplier B.
- busy  output  1  high in RUN and CHECK.
- checkValid  output  1  one-cycle pulse; verdict outputs are valid.
- mismatch  output  1  captured productA != productB.
- timingLeak  output  1  latencyA != latencyB.
- timeout  output  1  run aborted by TIMEOUT.
- latencyA  output  CNT_W  cycles from start to first productDoneA.
- latencyB  output  CNT_W  cycles from start to first productDoneB.
- capturedA  output  2*WIDTH  captured productA.
- capturedB  output  2*WIDTH  captured productB.
- leakSticky  output  1  set by any timingLeak verdict; cleared only by rst.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; every output and internal register is 0. This applies mid-run too: the run is discarded and checkValid does not pulse.
- FSM states: IDLE, RUN, CHECK.
- IDLE, start=1: go to RUN; cnt<=1; both lane capture flags cleared. Verdict outputs are cleared to 0 on this edge.
- IDLE, done inputs: ignored.
- RUN, each cycle:
  - For each lane not yet captured with productDone=1: captured<=product, latency<=cnt, flag<=1.
  - Only the first done per lane counts; later done cycles and held-high levels are ignored.
  - Both lanes can capture on the same edge.
  - cnt increments each cycle, saturating at TIMEOUT.
- RUN exit: go to CHECK on the edge where both flags are set, counting captures made on that edge. Otherwise, if cnt==TIMEOUT, go to CHECK with the abort marker set.
- start while busy: ignored; it neither restarts nor queues.
- CHECK (exactly one cycle): register the verdict, pulse checkValid=1, return to IDLE.
  - Normal run: mismatch=(capturedA!=capturedB), timingLeak=(latencyA!=latencyB), timeout=0.
  - Aborted run: timeout=1, mismatch=0, timingLeak=1 if exactly one lane captured, else 0.
  - leakSticky<=leakSticky|timingLeak.
- Verdict, latency and captured outputs hold their values until the next accepted start.
- Latency convention: done asserted on the cycle right after the start cycle gives latency 1.
- Arithmetic: equality compares only; no width growth beyond CNT_W.

Decomposition:
- Package multiplier_check_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, CHECK=2'd2;
  - the CNT_W derivation helper;
  - the verdict struct {mismatch, timingLeak, timeout}.
- Sub-module multiplier_result_capture is instantiated twice, once per lane. Inputs: clk, rst, clear, enable (RUN), cnt, product, productDone. Outputs: captured, latency, flag.
- The top level holds the FSM, counter, comparison and sticky flag.

Test Plan:
- Lane inputs held constant, WIDTH=4: start; both done on cycle 4 with product 8'h2A -> checkValid at cycle 6; mismatch=0, timingLeak=0, latencyA=latencyB=4.
- Skewed done: done A at cycle 4, done B at cycle 6, equal products 8'h0F -> latencyA=4, latencyB=6, timingLeak=1, leakSticky=1; leakSticky stays 1 after a later clean run.
- Product mismatch: both done at cycle 3, productA=8'h12, productB=8'h21 -> mismatch=1, timingLeak=0.
- Timeout, TIMEOUT=8: only done A at cycle 2 -> checkValid after cnt reaches 8; timeout=1, timingLeak=1, mismatch=0.
- Protocol edges:
  - done A held high for 5 cycles -> latencyA is the first cycle only;
  - start pulsed during RUN -> ignored, busy stays 1;
  - done asserted in IDLE -> no capture.
- rst=1 at cycle 3 of a run -> next cycle all outputs 0, state IDLE, no checkValid; a new start then runs normally.
